// File: rtl/qam_mapper.sv
// qam_mapper: maps up to 4 data bits per symbol onto BPSK, QPSK or 16-QAM
// I/Q points. Packed {Q,I} words are delivered through a 2-entry output buffer
// with valid/ready handshakes on both sides. It also keeps a wrapping count of
// accepted symbols and a sticky illegal-mode flag.
// Optional feature macro: QAM_MAPPER_16QAM_EN. When it is undefined, mode 2 is
// treated as reserved.
module qam_mapper #(
    parameter int DATA_W = 16,
    parameter int LEVEL  = 4096,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [3:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [2*DATA_W-1:0]   m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      sym_count,
    output logic                  err
);

    // The outer level 3*LEVEL has to be representable as a positive signed component.
    if ((32'sd3 * LEVEL) > ((64'sd1 <<< (DATA_W - 1)) - 64'sd1)) begin : g_level_chk
        $fatal(1, "qam_mapper: 3*LEVEL does not fit in signed DATA_W");
    end

    localparam logic [DATA_W-1:0] LVL_P1 = DATA_W'(LEVEL);
    localparam logic [DATA_W-1:0] LVL_N1 = DATA_W'(-LEVEL);
    localparam logic [DATA_W-1:0] LVL_P3 = DATA_W'(32'sd3 * LEVEL);
    localparam logic [DATA_W-1:0] LVL_N3 = DATA_W'(-(32'sd3 * LEVEL));

    // A single bit selects a BPSK/QPSK component: 0 maps to +L and 1 maps to -L.
    function automatic logic [DATA_W-1:0] bit_level(input logic b);
        return b ? LVL_N1 : LVL_P1;
    endfunction

`ifdef QAM_MAPPER_16QAM_EN
    // Gray-coded 16-QAM component: 00 -> -3L, 01 -> -L, 11 -> +L, 10 -> +3L.
    function automatic logic [DATA_W-1:0] gray_level(input logic [1:0] b);
        logic [DATA_W-1:0] v;
        case (b)
            2'b00:   v = LVL_N3;
            2'b01:   v = LVL_N1;
            2'b11:   v = LVL_P1;
            2'b10:   v = LVL_P3;
            default: v = {DATA_W{1'b0}};
        endcase
        return v;
    endfunction
`endif

    logic [1:0]          occ_q,   occ_d;
    logic [2*DATA_W-1:0] head_q,  head_d;
    logic [2*DATA_W-1:0] tail_q,  tail_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic [2*DATA_W-1:0] map_word_s;
    logic                map_bad_s;
    logic                push_s;
    logic                pop_s;

    assign push_s = s_valid && ready_q;
    assign pop_s  = (occ_q != 2'd0) && m_ready;

    // Map the incoming symbol bits to a packed {Q,I} word for the current mode.
    always_comb begin
        map_word_s = {(2*DATA_W){1'b0}};
        map_bad_s  = 1'b0;
        case (mode)
            2'd0: map_word_s = {{DATA_W{1'b0}}, bit_level(s_data[0])};
            2'd1: map_word_s = {bit_level(s_data[1]), bit_level(s_data[0])};
`ifdef QAM_MAPPER_16QAM_EN
            2'd2: map_word_s = {gray_level(s_data[3:2]), gray_level(s_data[1:0])};
`endif
            default: begin
                map_word_s = {(2*DATA_W){1'b0}};
                map_bad_s  = 1'b1;
            end
        endcase
    end

    // Buffer next state: head is the output word, and tail holds a second entry.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push_s && pop_s) begin
            // Only possible at occupancy 1, so the new word becomes the head.
            head_d = map_word_s;
        end else if (push_s) begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
                head_d = map_word_s;
            end else begin
                tail_d = map_word_s;
            end
        end else if (pop_s) begin
            occ_d = occ_q - 2'd1;
            if (occ_q == 2'd2) begin
                head_d = tail_q;
            end else begin
                head_d = head_q;
            end
        end else begin
            occ_d = occ_q;
        end
        ready_d = (occ_d < 2'd2);
        valid_d = (occ_d != 2'd0);
        cnt_d   = push_s ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;
        err_d   = err_q | (push_s & map_bad_s);
    end

    // State registers. Reset empties the buffer and clears the count and the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q   <= 2'd0;
            head_q  <= {(2*DATA_W){1'b0}};
            tail_q  <= {(2*DATA_W){1'b0}};
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign s_ready   = ready_q;
    assign m_valid   = valid_q;
    assign m_data    = head_q;
    assign sym_count = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Testbench for qam_mapper. A queue-based reference model predicts the outputs
// from the mapping rules. The bench applies directed and random symbols with back-pressure.
module tb_qam_mapper;
    localparam int DATA_W = 16;
    localparam int LEVEL  = 4096;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        mode;
    logic [3:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  sym_count;
    logic              err;

    qam_mapper #(.DATA_W(DATA_W), .LEVEL(LEVEL), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .sym_count(sym_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Reference model state
    logic [31:0] q_m[$];
    logic [31:0] exp_head;
    bit          exp_ready;
    bit          exp_err;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tot_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Map a symbol to {Q,I} using signed integer arithmetic derived from the constellation rules.
    function automatic logic [31:0] ref_map(input int md, input int d, output bit bad);
        int gray[4] = '{-3, -1, 3, 1};
        int iv;
        int qv;
        logic [15:0] i16;
        logic [15:0] q16;
        iv = 0; qv = 0; bad = 1'b0;
        if (md == 0) begin
            iv = ((d & 1) != 0) ? -LEVEL : LEVEL;
        end else if (md == 1) begin
            iv = ((d & 1) != 0) ? -LEVEL : LEVEL;
            qv = ((d & 2) != 0) ? -LEVEL : LEVEL;
        end else if (md == 2) begin
`ifdef QAM_MAPPER_16QAM_EN
            iv = gray[d & 3] * LEVEL;
            qv = gray[(d >> 2) & 3] * LEVEL;
`else
            bad = 1'b1;
`endif
        end else begin
            bad = 1'b1;
        end
        i16 = 16'(iv);
        q16 = 16'(qv);
        return {q16, i16};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".m_valid"},   m_valid,   (q_m.size() != 0));
        chk({tag, ".m_data"},    m_data,    exp_head);
        chk({tag, ".s_ready"},   s_ready,   exp_ready);
        chk({tag, ".sym_count"}, sym_count, exp_cnt % (1 << CNT_W));
        chk({tag, ".err"},       err,       exp_err);
    endtask

    // One clock: drive inputs, update the model at the edge, then check #1 after it.
    task automatic step(input string tag, input bit v, input int md, input int d, input bit mr);
        bit push;
        bit pop;
        bit bad;
        logic [31:0] w;
        s_valid = v;
        mode    = 2'(md);
        s_data  = 4'(d);
        m_ready = mr;
        @(posedge clk);
        push = v && exp_ready;
        pop  = (q_m.size() != 0) && mr;
        w    = ref_map(md, d, bad);
        if (pop) void'(q_m.pop_front());
        if (push) begin
            q_m.push_back(w);
            exp_cnt++;
            if (bad) exp_err = 1'b1;
        end
        if (q_m.size() != 0) exp_head = q_m[0];
        exp_ready = (q_m.size() < 2);
        #1;
        check_all(tag);
    endtask

    // Assert reset asynchronously, check the cleared outputs at once, then release at a falling edge.
    task automatic do_reset(input string tag);
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        q_m.delete();
        exp_head  = 32'h0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_cnt   = 0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; mode = 2'd0; s_data = 4'd0; s_valid = 1'b0; m_ready = 1'b1;
        #2;
        do_reset("reset");
        step("idle_after_reset", 1'b0, 0, 0, 1'b1);

        // BPSK: 0 -> +L and 1 -> -L, each visible one cycle after the push.
        step("bpsk0", 1'b1, 0, 0, 1'b1);
        chk("bpsk0_word", m_data, 32'h0000_1000);
        step("bpsk1", 1'b1, 0, 1, 1'b1);
        chk("bpsk1_word", m_data, 32'h0000_F000);
        step("bpsk_idle", 1'b0, 0, 0, 1'b1);
        chk("bpsk_count", sym_count, 4'd2);

        // QPSK back-to-back stream
        for (int k = 0; k < 4; k++) step("qpsk", 1'b1, 1, k, 1'b1);
        step("qpsk_idle", 1'b0, 1, 0, 1'b1);

        // 16-QAM symbols (mode 2 is reserved if the feature is compiled out)
        step("qam16_0", 1'b1, 2, 4'h0, 1'b1);
        step("qam16_6", 1'b1, 2, 4'h6, 1'b1);
        step("qam16_b", 1'b1, 2, 4'hB, 1'b1);
        step("qam16_idle", 1'b0, 2, 0, 1'b1);

        // Back-pressure: the third symbol is held while the buffer is full.
        do_reset("reset_bp");
        step("bp_wake", 1'b0, 1, 0, 1'b0);
        step("bp_push1", 1'b1, 1, 0, 1'b0);
        step("bp_push2", 1'b1, 1, 1, 1'b0);
        step("bp_hold3", 1'b1, 1, 2, 1'b0);
        step("bp_hold3b", 1'b1, 1, 2, 1'b0);
        step("bp_pop1", 1'b1, 1, 2, 1'b1);
        step("bp_push3", 1'b1, 1, 2, 1'b1);
        step("bp_drain1", 1'b0, 1, 0, 1'b1);
        step("bp_drain2", 1'b0, 1, 0, 1'b1);
        chk("bp_count", sym_count, 4'd3);

        // Illegal mode sets a sticky error flag.
        do_reset("reset_err");
        step("err_wake", 1'b0, 0, 0, 1'b1);
        step("err_legal", 1'b1, 1, 3, 1'b1);
        chk("err_clear_before", err, 1'b0);
        step("err_mode3", 1'b1, 3, 5, 1'b1);
        chk("err_mode3_word", m_data, 32'h0);
        step("err_after1", 1'b1, 0, 1, 1'b1);
        step("err_after2", 1'b1, 1, 2, 1'b1);
        chk("err_sticky", err, 1'b1);

        // Counter wrap after 17 pushes
        do_reset("reset_wrap");
        step("wrap_wake", 1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 17; k++) step("wrap", 1'b1, 0, k, 1'b1);
        chk("wrap_count", sym_count, 4'd1);

        // Random traffic with random back-pressure and modes
        for (int k = 0; k < 300; k++) begin
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a burst discards buffered data.
        step("mid_push1", 1'b1, 1, 1, 1'b0);
        step("mid_push2", 1'b1, 1, 2, 1'b0);
        do_reset("reset_mid");
        chk("mid_valid", m_valid, 1'b0);
        step("mid_wake", 1'b0, 0, 0, 1'b1);
        step("mid_post", 1'b1, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
